// File: rtl/mul_result_assembler_yjy.sv
// rtl/mul_result_assembler_yjy.sv - assembles eight column beats into a 64-bit product
// Optional residual-carry overflow flag: define MUL_RESULT_ASSEMBLER_OVF_EN.
module mul_result_assembler_yjy #(
    parameter int    UUID = 0,
    parameter string NAME = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_sum_16,
    input  logic [7:0]  i_carry_8,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [63:0] o_product_64,
    output logic [2:0]  o_beat_3,
    output logic        o_ovf
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t      state;
    logic [16:0] carry_reg;
    logic [24:0] t;
    logic        last_accept;

    // Carry byte sits 16 bits above the column sum; the running carry is already byte-shifted.
    assign t = {8'd0, carry_reg} + {9'd0, i_sum_16} + {1'b0, i_carry_8, 16'd0};

    assign last_accept = (state == COLLECT) && i_valid && (o_beat_3 == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= COLLECT;
            o_ready      <= 1'b1;
            o_valid      <= 1'b0;
            o_beat_3     <= 3'd0;
            carry_reg    <= 17'd0;
            o_product_64 <= 64'd0;
        end else begin
            case (state)
                COLLECT: begin
                    if (i_valid) begin
                        o_product_64[8*o_beat_3 +: 8] <= t[7:0];
                        o_beat_3                      <= o_beat_3 + 3'd1;
                        if (o_beat_3 == 3'd7) begin
                            carry_reg <= 17'd0;
                            state     <= HOLD;
                            o_ready   <= 1'b0;
                            o_valid   <= 1'b1;
                        end else begin
                            carry_reg <= t[24:8];
                        end
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        state   <= COLLECT;
                        o_ready <= 1'b1;
                        o_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= COLLECT;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUL_RESULT_ASSEMBLER_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_ovf <= 1'b0;
        end else if (last_accept) begin
            o_ovf <= (t[24:8] != 17'd0);
        end
    end
`else
    logic unused_last;
    assign unused_last = last_accept;
    assign o_ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_mul_result_assembler_yjy.sv
// tb/tb_mul_result_assembler_yjy.sv - directed self-checking bench for mul_result_assembler_yjy
module tb_mul_result_assembler_yjy;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_sum_16;
    logic [7:0]  i_carry_8;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] o_product_64;
    logic [2:0]  o_beat_3;
    logic        o_ovf;

    int checks = 0;
    int errors = 0;

`ifdef MUL_RESULT_ASSEMBLER_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    mul_result_assembler_yjy #(.UUID(3), .NAME("tb")) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_sum_16     (i_sum_16),
        .i_carry_8    (i_carry_8),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_product_64 (o_product_64),
        .o_beat_3     (o_beat_3),
        .o_ovf        (o_ovf)
    );

    always #5 clk = ~clk;

    // Column k of a byte-wise schoolbook multiply: sum of a_i*b_j with i+j=k.
    function automatic logic [24:0] column(input logic [31:0] a, input logic [31:0] b, input int k);
        logic [24:0] s;
        s = 25'd0;
        for (int i = 0; i < 4; i++) begin
            if (k - i >= 0 && k - i < 4)
                s = s + ({17'd0, a[8*i +: 8]} * {17'd0, b[8*(k-i) +: 8]});
        end
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic beat(input logic [15:0] s, input logic [7:0] c);
        i_valid   = 1'b1;
        i_sum_16  = s;
        i_carry_8 = c;
        @(negedge clk);
        i_valid   = 1'b0;
    endtask

    task automatic send_mul(input logic [31:0] a, input logic [31:0] b);
        logic [24:0] c;
        for (int k = 0; k < 8; k++) begin
            c = column(a, b, k);
            beat(c[15:0], c[23:16]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_sum_16 = 16'hDEAD; i_carry_8 = 8'hBE;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_beat_3 !== 3'd0 || o_product_64 !== 64'd0 || o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b beat=%0d prod=%h ovf=%b required rdy=1 vld=0 beat=0 prod=0 ovf=0",
                     o_ready, o_valid, o_beat_3, o_product_64, o_ovf);
        end
    endtask

    task automatic test_ones();
        i_ready = 1'b1;
        for (int k = 0; k < 7; k++) beat(16'h0001, 8'h00);
        checks++;
        if (o_valid !== 1'b0 || o_beat_3 !== 3'd7) begin
            errors++;
            $display("FAIL ones_pre_last: vld=%b beat=%0d required vld=0 beat=7", o_valid, o_beat_3);
        end
        beat(16'h0001, 8'h00);
        checks++;
        if (o_valid !== 1'b1 || o_product_64 !== 64'h0101010101010101 || o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ones_result: vld=%b prod=%h ovf=%b required vld=1 prod=0101010101010101 ovf=0",
                     o_valid, o_product_64, o_ovf);
        end
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_beat_3 !== 3'd0) begin
            errors++;
            $display("FAIL ones_pulse: vld=%b rdy=%b beat=%0d required vld=0 rdy=1 beat=0", o_valid, o_ready, o_beat_3);
        end
        i_ready = 1'b0;
    endtask

    task automatic test_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] gold;
        gold = {32'd0, a} * {32'd0, b};
        send_mul(a, b);
        checks++;
        if (o_valid !== 1'b1 || o_product_64 !== gold || o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL mul_%h_%h: vld=%b prod=%h ovf=%b required vld=1 prod=%h ovf=0",
                     a, b, o_valid, o_product_64, o_ovf, gold);
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    task automatic test_carry_byte();
        beat(16'hFFFF, 8'hFF);
        for (int k = 0; k < 7; k++) beat(16'h0000, 8'h00);
        checks++;
        if (o_product_64 !== 64'h0000000000FFFFFF || o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL carry_byte: prod=%h ovf=%b required prod=0000000000ffffff ovf=0", o_product_64, o_ovf);
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    task automatic test_ovf();
        for (int k = 0; k < 7; k++) beat(16'h0000, 8'h00);
        beat(16'h0100, 8'h00);
        checks++;
        if (o_product_64 !== 64'd0 || o_ovf !== OVF_ON) begin
            errors++;
            $display("FAIL ovf_flag: prod=%h ovf=%b required prod=0 ovf=%b", o_product_64, o_ovf, OVF_ON);
        end
        for (int k = 0; k < 3; k++) @(negedge clk);
        checks++;
        if (o_ovf !== OVF_ON || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold: ovf=%b vld=%b required ovf=%b vld=1", o_ovf, o_valid, OVF_ON);
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    task automatic test_hold();
        logic [63:0] gold;
        gold = 64'h0000000012345678 * 64'h000000009ABCDEF0;
        send_mul(32'h12345678, 32'h9ABCDEF0);
        for (int n = 0; n < 5; n++) begin
            i_valid   = 1'b1;
            i_sum_16  = 16'h1111 * 16'(n + 1);
            i_carry_8 = 8'h22;
            @(negedge clk);
            checks++;
            if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_product_64 !== gold || o_beat_3 !== 3'd0) begin
                errors++;
                $display("FAIL hold_cycle%0d: rdy=%b vld=%b prod=%h beat=%0d required rdy=0 vld=1 prod=%h beat=0",
                         n, o_ready, o_valid, o_product_64, o_beat_3, gold);
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_beat_3 !== 3'd0 || o_product_64 !== gold) begin
            errors++;
            $display("FAIL hold_release: rdy=%b vld=%b beat=%0d prod=%h required rdy=1 vld=0 beat=0 prod=%h",
                     o_ready, o_valid, o_beat_3, o_product_64, gold);
        end
        @(negedge clk);
        checks++;
        if (o_product_64 !== gold || o_beat_3 !== 3'd0) begin
            errors++;
            $display("FAIL bubble: prod=%h beat=%0d required prod=%h beat=0", o_product_64, o_beat_3, gold);
        end
        beat(16'h00AB, 8'h00);
        checks++;
        if (o_product_64 !== {gold[63:8], 8'hAB} || o_beat_3 !== 3'd1) begin
            errors++;
            $display("FAIL next_beat_idx0: prod=%h beat=%0d required prod=%h beat=1",
                     o_product_64, o_beat_3, {gold[63:8], 8'hAB});
        end
        do_reset();
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 4; k++) beat(16'h0F0F, 8'h03);
        checks++;
        if (o_beat_3 !== 3'd4) begin
            errors++;
            $display("FAIL mid_beat_count: beat=%0d required 4", o_beat_3);
        end
        do_reset();
        checks++;
        if (o_beat_3 !== 3'd0 || o_product_64 !== 64'd0 || o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: beat=%0d prod=%h rdy=%b vld=%b required beat=0 prod=0 rdy=1 vld=0",
                     o_beat_3, o_product_64, o_ready, o_valid);
        end
        test_mul(32'hCAFEF00D, 32'h0BADBEEF);
    endtask

    initial begin
        test_reset();
        test_ones();
        test_mul(32'hFFFFFFFF, 32'hFFFFFFFF);
        test_carry_byte();
        test_ovf();
        test_mul(32'h00000003, 32'h00000005);
        test_hold();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
